// File: rtl/fb_pkg.sv
// Shared definitions for the double-buffered frame buffer and the sprite engine:
// FSM state encoding, default geometry, pixel key codes and an address-width helper.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CLEAR   = 2'd2
  } fb_state_t;

  localparam int FB_DEF_H_RES = 640;
  localparam int FB_DEF_V_RES = 480;
  localparam int FB_DEF_PIX_W = 5;

  // Codes shared with the sprite engine
  localparam logic [4:0] FB_DEF_TRANSP_KEY = 5'h15;
  localparam logic [4:0] FB_DEF_BG_COLOR   = 5'h00;

  // Address width needed to hold h_res*v_res linear pixel addresses
  function automatic int fb_addr_w(input int h_res, input int v_res);
    return ((h_res * v_res) > 1) ? $clog2(h_res * v_res) : 1;
  endfunction

  localparam int FB_DEF_ADDR_W = fb_addr_w(FB_DEF_H_RES, FB_DEF_V_RES);

endpackage

// File: rtl/fb_bank.sv
// One frame-buffer bank: a single write port and a registered (synchronous)
// read port. Memory contents are not reset; only the read register is.
module fb_bank
  import fb_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PIX_W = 5,
  parameter int AW    = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PIX_W-1:0] rdata_q;

  // Pixel storage write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Synchronous read register, cleared by reset so the scan output starts at zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_dbl.sv
// Double-buffered (ping-pong) frame buffer. The draw engine writes the back
// bank through a valid/ready handshake while the scan path reads the front
// bank; a requested swap takes effect on the next VS falling edge.
// Optional build macro FB_CLEAR_EN: after every swap the new back bank is
// filled with BG_COLOR, one word per cycle, with writes stalled meanwhile.
module frame_buffer_dbl
  import fb_pkg::*;
#(
  parameter int               H_RES      = FB_DEF_H_RES,
  parameter int               V_RES      = FB_DEF_V_RES,
  parameter int               PIX_W      = FB_DEF_PIX_W,
  parameter logic [PIX_W-1:0] TRANSP_KEY = PIX_W'(FB_DEF_TRANSP_KEY),
  parameter logic [PIX_W-1:0] BG_COLOR   = PIX_W'(FB_DEF_BG_COLOR)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             VS,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  output logic [PIX_W-1:0] pixelOut,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [9:0]       wr_x,
  input  logic [9:0]       wr_y,
  input  logic [PIX_W-1:0] wr_pixel,
  input  logic             swap_req,
  output logic             swap_done,
  output logic             busy
);

  localparam int DEPTH  = H_RES * V_RES;
  localparam int ADDR_W = fb_addr_w(H_RES, V_RES);
`ifdef FB_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
`endif

  // Linear address y*H_RES + x, truncated to the bank address width
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [9:0] x, input logic [9:0] y);
    logic [31:0] a;
    a = (32'(y) * 32'(H_RES)) + 32'(x);
    return a[ADDR_W-1:0];
  endfunction

  // Control state
  fb_state_t   state_q;
  logic        front_sel_q;
  logic        pending_q;
  logic        busy_q;
  logic        vs_q;
  logic        run_q;
`ifdef FB_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt_q;
`endif

  // Read-side pipeline
  logic              rd_oor_q;
  logic              rd_sel_q;
  logic              rd_in_range_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [PIX_W-1:0]  rdata0_s;
  logic [PIX_W-1:0]  rdata1_s;

  // Write-side decode
  logic              vs_fall_s;
  logic              swap_fire_s;
  logic              wr_ready_s;
  logic              wr_in_range_s;
  logic              wr_keep_s;
  logic              clear_we_s;
  logic              bank_we_s;
  logic [ADDR_W-1:0] bank_waddr_s;
  logic [PIX_W-1:0]  bank_wdata_s;
  logic              we0_s;
  logic              we1_s;

  assign vs_fall_s = vs_q & ~VS;

  // Swap fires on a VS falling edge when a swap is pending, or when a fresh
  // request in IDLE coincides with the edge.
  always_comb begin
    swap_fire_s = 1'b0;
    if (vs_fall_s) begin
      swap_fire_s = ((state_q == IDLE) & swap_req) | ((state_q == WAIT_VS) & pending_q);
    end else begin
      swap_fire_s = 1'b0;
    end
  end

  // Writes are accepted in IDLE/WAIT_VS except in the swap cycle, so nothing
  // lands in the bank that is being promoted to front.
  always_comb begin
    wr_ready_s = 1'b0;
    case (state_q)
      IDLE, WAIT_VS: wr_ready_s = run_q & ~swap_fire_s;
      default:       wr_ready_s = 1'b0;
    endcase
  end

  assign wr_in_range_s = (32'(wr_x) < H_RES) && (32'(wr_y) < V_RES);
  assign wr_keep_s     = wr_valid & wr_ready_s & wr_in_range_s & (wr_pixel != TRANSP_KEY);

`ifdef FB_CLEAR_EN
  assign clear_we_s = (state_q == CLEAR);
`else
  assign clear_we_s = 1'b0;
`endif

  // Back-bank write mux: clear engine has priority (draw writes are stalled then)
  always_comb begin
    bank_waddr_s = '0;
    bank_wdata_s = '0;
    if (clear_we_s) begin
`ifdef FB_CLEAR_EN
      bank_waddr_s = clr_cnt_q;
`else
      bank_waddr_s = '0;
`endif
      bank_wdata_s = BG_COLOR;
    end else if (wr_in_range_s) begin
      bank_waddr_s = lin_addr(wr_x, wr_y);
      bank_wdata_s = wr_pixel;
    end else begin
      bank_waddr_s = '0;
      bank_wdata_s = wr_pixel;
    end
  end

  assign bank_we_s = wr_keep_s | clear_we_s;
  assign we0_s     = bank_we_s & front_sel_q;
  assign we1_s     = bank_we_s & ~front_sel_q;

  // Read address decode; out-of-range reads use address 0 and are masked later
  always_comb begin
    rd_in_range_s = (32'(DrawX) < H_RES) && (32'(DrawY) < V_RES);
    if (rd_in_range_s) begin
      rd_addr_s = lin_addr(DrawX, DrawY);
    end else begin
      rd_addr_s = '0;
    end
  end

  fb_bank #(.DEPTH(DEPTH), .PIX_W(PIX_W), .AW(ADDR_W)) u_bank0 (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .we_i   (we0_s),
    .waddr_i(bank_waddr_s),
    .wdata_i(bank_wdata_s),
    .raddr_i(rd_addr_s),
    .rdata_o(rdata0_s)
  );

  fb_bank #(.DEPTH(DEPTH), .PIX_W(PIX_W), .AW(ADDR_W)) u_bank1 (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .we_i   (we1_s),
    .waddr_i(bank_waddr_s),
    .wdata_i(bank_wdata_s),
    .raddr_i(rd_addr_s),
    .rdata_o(rdata1_s)
  );

  // Capture the front selection and range flag alongside the bank read
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_oor_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      rd_oor_q <= ~rd_in_range_s;
      rd_sel_q <= front_sel_q;
    end
  end

  // Output mux over the registered bank reads
  always_comb begin
    pixelOut = '0;
    if (rd_oor_q) begin
      pixelOut = BG_COLOR;
    end else if (rd_sel_q) begin
      pixelOut = rdata1_s;
    end else begin
      pixelOut = rdata0_s;
    end
  end

  // Swap/clear FSM with VS edge register and clear counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      front_sel_q <= 1'b0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      vs_q        <= 1'b1;
      run_q       <= 1'b0;
`ifdef FB_CLEAR_EN
      clr_cnt_q   <= '0;
`endif
    end else begin
      vs_q  <= VS;
      run_q <= 1'b1;
      case (state_q)
        IDLE, WAIT_VS: begin
          if (swap_fire_s) begin
            front_sel_q <= ~front_sel_q;
            pending_q   <= 1'b0;
`ifdef FB_CLEAR_EN
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            busy_q      <= 1'b1;
`else
            state_q     <= IDLE;
            busy_q      <= 1'b0;
`endif
          end else if ((state_q == IDLE) && swap_req) begin
            state_q   <= WAIT_VS;
            pending_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        CLEAR: begin
`ifdef FB_CLEAR_EN
          if (clr_cnt_q == CLR_LAST) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end
`else
          state_q <= IDLE;
          busy_q  <= 1'b0;
`endif
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready  = wr_ready_s;
  assign swap_done = swap_fire_s;
  assign busy      = busy_q;

endmodule
